// File: rtl/bitwise_pipe16_if.sv
// Handshake bundle for bitwise_pipe16: operand side (in_*) and result side (out_*).
// master: upstream producer / downstream consumer view; slave: the pipeline stage itself.
interface bitwise_pipe16_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/bitwise_pipe16.sv
// bitwise_pipe16: registered bitwise logic stage (AND/OR/XOR/NAND).
// Operands are buffered in a DEPTH-entry FIFO; the FIFO head feeds the gate and
// the result is captured in an output register with valid/ready handoff.
// Optional build macro BITWISE_PIPE16_STATS_EN adds result_count and stall_seen.
module bitwise_pipe16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  bitwise_pipe16_if.slave  bus
`ifdef BITWISE_PIPE16_STATS_EN
  ,
  output logic [15:0]      result_count,
  output logic             stall_seen
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  op_e              mem_op [DEPTH];

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic             in_ready_w;
  logic             push;
  logic             pop;
  logic             handoff;
  logic [WIDTH-1:0] result;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;

  // Ready depends on FIFO occupancy only, never on out_ready.
  assign in_ready_w = (count != CW'(DEPTH));
  assign push       = bus.in_valid && in_ready_w;
  assign pop        = (count != '0) && (!out_valid_q || bus.out_ready);
  assign handoff    = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;

  // FIFO storage: payload only, no reset needed since pointers/count gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= bus.in_a;
      mem_b[wr_ptr]  <= bus.in_b;
      mem_op[wr_ptr] <= op_e'(bus.in_op);
    end
  end

  // Bitwise gate driven by the FIFO head.
  always_comb begin
    result = '0;
    unique case (mem_op[rd_ptr])
      OP_AND:  result = mem_a[rd_ptr] & mem_b[rd_ptr];
      OP_OR:   result = mem_a[rd_ptr] | mem_b[rd_ptr];
      OP_XOR:  result = mem_a[rd_ptr] ^ mem_b[rd_ptr];
      OP_NAND: result = ~(mem_a[rd_ptr] & mem_b[rd_ptr]);
      default: result = '0;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register: load on pop, otherwise drop valid after a handoff and hold data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
      out_zero_q  <= (result == '0);
    end else if (handoff) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef BITWISE_PIPE16_STATS_EN
  // Handshake counter (wraps) and sticky backpressure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count <= '0;
      stall_seen   <= 1'b0;
    end else begin
      if (handoff) result_count <= result_count + 16'd1;
      if (out_valid_q && !bus.out_ready) stall_seen <= 1'b1;
    end
  end
`endif

endmodule
